// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared constants, types and helpers for the score display controller
//
// Purpose: widths, limits, FSM state type and the double-dabble nibble
// adjust used by the serial converter and the controller.
// Ports: none (package).

package score_display_pkg;

   localparam int SCORE_W = 20;
   localparam int DIGITS  = 6;
   localparam int BCD_W   = 24;
   localparam int ITERS   = 20;
   localparam logic [SCORE_W-1:0] SCORE_MAX = 20'd999999;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   typedef logic [BCD_W-1:0] bcd_t;

   // Add 3 to every nibble that is 5 or more; 4-bit add, carry-out dropped.
   function automatic bcd_t dd_adjust(input bcd_t v);
      bcd_t r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   function automatic logic [SCORE_W-1:0] clip_score(input logic [SCORE_W-1:0] s);
      return (s > SCORE_MAX) ? SCORE_MAX : s;
   endfunction

endpackage

// File: rtl/bcd_dd_serial.sv
// rtl/bcd_dd_serial.sv - serial double-dabble binary to BCD converter, one iteration per cycle
//
// Purpose: loads a pre-clipped binary score on start, then runs ITERS
// add-3/shift iterations. done is high during the cycle whose closing edge
// performs the last iteration, so bcd is final in the following cycle.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   start in   load bin and restart the iteration counter
//   bin   in   20-bit binary value (must already be <= 999999)
//   bcd   out  24-bit BCD working/result register
//   done  out  last iteration happens on the next edge

module bcd_dd_serial
   import score_display_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin,
   output logic [BCD_W-1:0]   bcd,
   output logic               done
);

   localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

   logic [SCORE_W-1:0] bin_q, bin_d;
   bcd_t               bcd_q, bcd_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               busy_q, busy_d;

   assign done = busy_q && (cnt_q == LAST_ITER);
   assign bcd  = bcd_q;

   always_comb begin
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start) begin
         bin_d  = bin;
         bcd_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Adjust first, then shift the next binary MSB into the units nibble.
         bcd_d = (dd_adjust(bcd_q) << 1) | {{(BCD_W-1){1'b0}}, bin_q[SCORE_W-1]};
         bin_d = bin_q << 1;
         if (cnt_q == LAST_ITER) begin
            cnt_d  = '0;
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - score update sequencer committing BCD and blank mask atomically
//
// Purpose: accepts a score over valid/ready, saturates it to 999999, runs the
// serial converter and commits digits, blank mask and saturation flag on one edge.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   score_valid  in   new score offered
//   score        in   20-bit binary score
//   blank_lz_en  in   leading-zero blanking enable, sampled at handshake
//   score_ready  out  high exactly in IDLE
//   bcd_out      out  committed BCD score, nibble 0 = units
//   digit_blank  out  per-digit blank drive
//   sat          out  last committed score was saturated
//   update_done  out  one-cycle pulse with the first cycle of new bcd_out

module score_display_ctrl
   import score_display_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               score_valid,
   input  logic [SCORE_W-1:0] score,
   input  logic               blank_lz_en,
   output logic               score_ready,
   output logic [BCD_W-1:0]   bcd_out,
   output logic [DIGITS-1:0]  digit_blank,
   output logic               sat,
   output logic               update_done
);

   state_t             state_q, state_d;
   logic               sat_next_q, sat_next_d;
   logic               lz_en_q, lz_en_d;
   bcd_t               bcd_out_q, bcd_out_d;
   logic [DIGITS-1:0]  digit_blank_q, digit_blank_d;
   logic               sat_q, sat_d;
   logic               update_done_q, update_done_d;

   logic               handshake;
   logic               conv_done;
   bcd_t               conv_bcd;
   logic [DIGITS-1:0]  blank_mask;

   assign handshake = score_valid && (state_q == IDLE);

   bcd_dd_serial u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (handshake),
      .bin   (clip_score(score)),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

   // Walk down from the top digit; a digit blanks only while every digit
   // above it (and itself) is zero. The units digit always shows.
   always_comb begin
      logic zero_run;
      zero_run   = 1'b1;
      blank_mask = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run      = zero_run && (conv_bcd[i*4 +: 4] == 4'd0);
         blank_mask[i] = lz_en_q && zero_run;
      end
   end

   always_comb begin
      state_d       = state_q;
      sat_next_d    = sat_next_q;
      lz_en_d       = lz_en_q;
      bcd_out_d     = bcd_out_q;
      digit_blank_d = digit_blank_q;
      sat_d         = sat_q;
      update_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               sat_next_d = (score > SCORE_MAX);
               lz_en_d    = blank_lz_en;
               state_d    = CONVERT;
            end
         end
         CONVERT: begin
            if (conv_done) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            bcd_out_d     = conv_bcd;
            digit_blank_d = blank_mask;
            sat_d         = sat_next_q;
            update_done_d = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sat_next_q    <= 1'b0;
         lz_en_q       <= 1'b0;
         bcd_out_q     <= '0;
         digit_blank_q <= '0;
         sat_q         <= 1'b0;
         update_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sat_next_q    <= sat_next_d;
         lz_en_q       <= lz_en_d;
         bcd_out_q     <= bcd_out_d;
         digit_blank_q <= digit_blank_d;
         sat_q         <= sat_d;
         update_done_q <= update_done_d;
      end
   end

   assign score_ready = (state_q == IDLE);
   assign bcd_out     = bcd_out_q;
   assign digit_blank = digit_blank_q;
   assign sat         = sat_q;
   assign update_done = update_done_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - self-checking bench for score_display_ctrl

module tb_score_display_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        score_valid = 1'b0;
   logic [19:0] score = '0;
   logic        blank_lz_en = 1'b0;
   logic        score_ready;
   logic [23:0] bcd_out;
   logic [5:0]  digit_blank;
   logic        sat;
   logic        update_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   score_display_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .score_valid (score_valid),
      .score       (score),
      .blank_lz_en (blank_lz_en),
      .score_ready (score_ready),
      .bcd_out     (bcd_out),
      .digit_blank (digit_blank),
      .sat         (sat),
      .update_done (update_done)
   );

   // Reference: decimal digits of the clipped score by repeated division.
   function automatic logic [23:0] model_bcd(input int unsigned v);
      int unsigned c;
      logic [23:0] r;
      c = (v > 999999) ? 999999 : v;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[i*4 +: 4] = 4'(c % 10);
         c = c / 10;
      end
      return r;
   endfunction

   // Reference: digits at or beyond the significant-digit count are blanked.
   function automatic logic [5:0] model_blank(input int unsigned v, input logic lz);
      int unsigned c;
      int nd;
      logic [5:0] r;
      c  = (v > 999999) ? 999999 : v;
      nd = 1;
      while (c >= 10) begin
         c = c / 10;
         nd++;
      end
      r = '0;
      for (int i = 0; i < 6; i++) r[i] = lz && (i >= nd);
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      score_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Handshake one score; returns cycles from handshake edge to update_done
   // (-1 on timeout) and whether any output moved before the commit.
   task automatic run_update(input logic [19:0] s, input logic lz,
                             output int lat, output bit steady_bad);
      logic [23:0] pb;
      logic [5:0]  pbl;
      logic        ps;
      int          w;
      @(negedge clk);
      score = s;
      blank_lz_en = lz;
      score_valid = 1'b1;
      w = 0;
      while (!score_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      pb = bcd_out;
      pbl = digit_blank;
      ps = sat;
      @(posedge clk);
      @(negedge clk);
      score_valid = 1'b0;
      lat = -1;
      steady_bad = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (update_done) begin
            lat = j;
            break;
         end
         if (score_ready !== 1'b0 || bcd_out !== pb || digit_blank !== pbl || sat !== ps)
            steady_bad = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      repeat (5) @(negedge clk);
      checks++; if (score_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", score_ready); end
      checks++; if (bcd_out !== 24'h0) begin errors++; $display("FAIL reset_bcd got %h expected 000000", bcd_out); end
      checks++; if (digit_blank !== 6'b0) begin errors++; $display("FAIL reset_blank got %b expected 000000", digit_blank); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b expected 0", sat); end
      checks++; if (update_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", update_done); end
   endtask

   task automatic test_basic();
      int lat;
      bit bad;
      run_update(20'd123456, 1'b0, lat, bad);
      checks++; if (lat !== 21) begin errors++; $display("FAIL basic_latency got %0d expected 21", lat); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL basic_steady got %b expected 0", bad); end
      checks++; if (bcd_out !== 24'h123456) begin errors++; $display("FAIL basic_bcd got %h expected 123456", bcd_out); end
      checks++; if (digit_blank !== 6'b0) begin errors++; $display("FAIL basic_blank got %b expected 000000", digit_blank); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b expected 0", sat); end
      checks++; if (score_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b expected 1", score_ready); end
      @(negedge clk);
      checks++; if (update_done !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b expected 0", update_done); end
   endtask

   task automatic test_blanking();
      int lat;
      bit bad;
      run_update(20'd42, 1'b1, lat, bad);
      checks++; if (bcd_out !== 24'h000042) begin errors++; $display("FAIL blank42_bcd got %h expected 000042", bcd_out); end
      checks++; if (digit_blank !== 6'b111100) begin errors++; $display("FAIL blank42_mask got %b expected 111100", digit_blank); end
      run_update(20'd0, 1'b1, lat, bad);
      checks++; if (bcd_out !== 24'h000000) begin errors++; $display("FAIL blank0_bcd got %h expected 000000", bcd_out); end
      checks++; if (digit_blank !== 6'b111110) begin errors++; $display("FAIL blank0_mask got %b expected 111110", digit_blank); end
   endtask

   task automatic test_saturation();
      int lat;
      bit bad;
      run_update(20'd1048575, 1'b0, lat, bad);
      checks++; if (bcd_out !== 24'h999999) begin errors++; $display("FAIL sat_max_bcd got %h expected 999999", bcd_out); end
      checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_max_flag got %b expected 1", sat); end
      run_update(20'd999999, 1'b0, lat, bad);
      checks++; if (bcd_out !== 24'h999999) begin errors++; $display("FAIL sat_edge_bcd got %h expected 999999", bcd_out); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_edge_flag got %b expected 0", sat); end
   endtask

   task automatic test_reset_midway();
      int lat;
      bit bad;
      bit seen;
      @(negedge clk);
      score = 20'd555555;
      blank_lz_en = 1'b0;
      score_valid = 1'b1;
      @(posedge clk);              // handshake edge T
      @(negedge clk);
      score_valid = 1'b0;
      repeat (9) @(negedge clk);   // cycle after T+9
      rst = 1'b1;
      @(posedge clk);              // edge T+10
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bcd_out !== 24'h0) begin errors++; $display("FAIL abort_bcd got %h expected 000000", bcd_out); end
      checks++; if (score_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b expected 1", score_ready); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL abort_sat got %b expected 0", sat); end
      seen = 1'b0;
      for (int j = 0; j < 30; j++) begin
         if (update_done) seen = 1'b1;
         @(negedge clk);
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b expected 0", seen); end
      run_update(20'd7, 1'b0, lat, bad);
      checks++; if (lat !== 21) begin errors++; $display("FAIL abort_next_latency got %0d expected 21", lat); end
      checks++; if (bcd_out !== 24'h000007) begin errors++; $display("FAIL abort_next_bcd got %h expected 000007", bcd_out); end
   endtask

   task automatic test_back_to_back();
      int hs[$];
      logic [23:0] seq[$];
      logic [23:0] last;
      int nd;
      do_reset();
      last = bcd_out;
      nd = 0;
      score = 20'd100000;
      blank_lz_en = 1'b0;
      score_valid = 1'b1;
      for (int c = 0; c < 70; c++) begin
         if (bcd_out !== last) begin
            seq.push_back(bcd_out);
            last = bcd_out;
         end
         if (update_done) begin
            nd++;
            if (nd == 1) score = 20'd200000;
            if (nd == 2) score_valid = 1'b0;
         end
         if (score_valid && score_ready) hs.push_back(c);
         @(negedge clk);
      end
      score_valid = 1'b0;
      checks++; if (hs.size() !== 2) begin errors++; $display("FAIL b2b_handshakes got %0d expected 2", hs.size()); end
      if (hs.size() >= 2) begin
         checks++; if (hs[1] - hs[0] !== 22) begin errors++; $display("FAIL b2b_spacing got %0d expected 22", hs[1] - hs[0]); end
      end
      checks++; if (seq.size() !== 2) begin errors++; $display("FAIL b2b_value_count got %0d expected 2", seq.size()); end
      if (seq.size() >= 2) begin
         checks++; if (seq[0] !== 24'h100000) begin errors++; $display("FAIL b2b_first got %h expected 100000", seq[0]); end
         checks++; if (seq[1] !== 24'h200000) begin errors++; $display("FAIL b2b_second got %h expected 200000", seq[1]); end
      end
   endtask

   task automatic test_random();
      int lat;
      bit bad;
      int unsigned v;
      logic lz;
      for (int k = 0; k < 10; k++) begin
         v  = (k % 3 == 0) ? $urandom_range(0, 999) : $urandom_range(0, 1048575);
         lz = 1'($urandom_range(0, 1));
         run_update(20'(v), lz, lat, bad);
         checks++; if (lat !== 21 || bad !== 1'b0) begin errors++; $display("FAIL rand_timing v=%0d got lat %0d steady_bad %b expected 21 0", v, lat, bad); end
         checks++; if (bcd_out !== model_bcd(v)) begin errors++; $display("FAIL rand_bcd v=%0d got %h expected %h", v, bcd_out, model_bcd(v)); end
         checks++; if (digit_blank !== model_blank(v, lz)) begin errors++; $display("FAIL rand_blank v=%0d got %b expected %b", v, digit_blank, model_blank(v, lz)); end
         checks++; if (sat !== (v > 999999)) begin errors++; $display("FAIL rand_sat v=%0d got %b expected %b", v, sat, (v > 999999)); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blanking();
      test_saturation();
      test_reset_midway();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Sequencing controller for the six-digit score display. It accepts score updates over a valid/ready handshake and saturates out-of-range values. It runs a multi-cycle serial double-dabble conversion and commits the BCD result plus a leading-zero blanking mask in a single cycle, so the seven-segment decoders never see a partially converted value. It sits between the game-logic score source and the per-digit segment decoders, replacing the combinational binary-to-BCD path.

## Interface
- Parameters: none. Widths are fixed by package constants: SCORE_W = 20, DIGITS = 6, BCD_W = 24.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- score_valid  in  1  a new score is offered.
- score  in  20  unsigned binary score; must be held stable while score_valid is high and score_ready is low.
- blank_lz_en  in  1  leading-zero blanking enable; sampled at handshake.
- score_ready  out  1  controller can accept a score; high exactly when the FSM is in IDLE.
- bcd_out  out  24  committed BCD score; nibble i is digit i, with digit 0 the units.
- digit_blank  out  6  bit i high means segment decoder i is driven blank.
- sat  out  1  last committed score was saturated.
- update_done  out  1  one-cycle pulse, coincident with the first cycle of new bcd_out.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - On score_valid & score_ready at an edge, latch the clipped score, where clipped = min(score, 999999).
  - Latch sat_next = (score > 999999) and lz_en = blank_lz_en.
  - Pulse start to the converter and move to CONVERT.
- CONVERT:
  - The converter performs one double-dabble iteration per cycle: add 3 to every nibble ≥ 5, then shift left one bit, bringing in the next binary MSB.
  - A 5-bit iteration counter runs 0..19. On the edge that completes iteration 19, move to COMMIT.
- COMMIT:
  - Register bcd_out = converter result and sat = sat_next.
  - Register digit_blank[i] = lz_en & (digits i..5 all zero), for i = 1..5. digit_blank[0] is always 0.
  - Assert update_done for the following cycle and return to IDLE.
- bcd_out, digit_blank and sat change only on the COMMIT edge or on reset. They hold otherwise, including throughout CONVERT.
- score and blank_lz_en are ignored outside IDLE. There is no queueing: a source holding score_valid high is accepted on the next IDLE cycle.
- Reset values: score_ready 1 in the cycle after reset; bcd_out 0; digit_blank 0; sat 0; update_done 0; FSM IDLE; iteration counter 0; converter registers 0.
- Reset during CONVERT or COMMIT abandons the conversion. Outputs take their reset values and no update_done is issued.
- Arithmetic: each converter nibble add is 4-bit with no carry-out. The input is pre-clipped, so no nibble exceeds 9 after the final shift.

## Timing
- Handshake edge T: state becomes CONVERT and score_ready falls in the cycle after T.
- Iterations run on edges T+1..T+20. State is COMMIT in the cycle after T+20.
- Edge T+21 commits the outputs. In the cycle after T+21:
  - new bcd_out, digit_blank and sat are visible;
  - update_done = 1 and score_ready = 1.
- The earliest next handshake is edge T+22. Throughput is one update per 22 cycles. Latency from handshake to visible result is 21 edges.
- rst asserted at edge R forces IDLE and reset outputs in the cycle after R, regardless of score_valid at R.

## Structure
- Package score_display_pkg holds:
  - constants SCORE_W, DIGITS, BCD_W, SCORE_MAX = 999999, ITERS = 20;
  - typedef state_t enum {IDLE, CONVERT, COMMIT};
  - typedef bcd_t logic [BCD_W-1:0].
- One sub-module, bcd_dd_serial:
  - ports clk, rst, start, bin[19:0], bcd[23:0], done;
  - owns the shift/add register and the iteration counter.
- The top controller owns the FSM, clipping, blank-mask generation and output registers.
- digit_blank feeds the existing segment decoders through an external blank gate. The decoders are not modified.

## Test plan
- Reset, then idle 5 cycles → score_ready = 1, bcd_out = 0x000000, digit_blank = 6'b000000, sat = 0, update_done = 0.
- score = 123456, blank_lz_en = 0, handshake at T → bcd_out = 0x123456, digit_blank = 0, sat = 0, update_done pulse in the cycle after T+21; score_ready low in cycles T+1..T+21.
- score = 42, blank_lz_en = 1 → bcd_out = 0x000042, digit_blank = 6'b111100. Then score = 0, blank_lz_en = 1 → bcd_out = 0x000000, digit_blank = 6'b111110.
- score = 1048575 → bcd_out = 0x999999, sat = 1. Then score = 999999 → bcd_out = 0x999999, sat = 0.
- Handshake score = 555555, rst at T+10, score_valid low afterwards → no update_done; bcd_out = 0 in the cycle after T+10; score_ready = 1; a new score = 7 then commits 0x000007 21 edges after its handshake.
- score_valid held high with score = 100000, then 200000 changed on the update_done cycle → handshakes exactly 22 edges apart; bcd_out sequence 0x100000 then 0x200000; bcd_out never shows an intermediate value.
